// File: rtl/muldiv_unit_if.sv
// Handshake and operand bus between the execute stage and muldiv_unit.
// The master side (core/bench) drives operands and start/flush; the slave
// side (muldiv_unit) returns busy/done and the registered result.
interface muldiv_unit_if #(
  parameter int N = 32
);
  logic         start_i;
  logic         flush_i;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic [2:0]   op_i;
  logic         busy_o;
  logic         done_o;
  logic [N-1:0] res_o;

  modport master (
    output start_i, flush_i, a_i, b_i, op_i,
    input  busy_o, done_o, res_o
  );

  modport slave (
    input  start_i, flush_i, a_i, b_i, op_i,
    output busy_o, done_o, res_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with a sign-fixup cycle before DONE.
// Define MULDIV_DIV_EN to build the divider; without it, ops 100-111
// complete in one cycle with a zero result.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide iteration per cycle, counter 0..N-1
// FIX   | apply signs, write result
// DONE  | done pulse; a new start is accepted here
module muldiv_unit #(
  parameter int N = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [N-1:0]    r_d;
  logic [2*N:0]    r_acc;
  logic            r_neg_q;
  logic            r_busy;
  logic            r_done;
  logic [N-1:0]    r_res;

  logic            w_a_neg;
  logic            w_b_neg;
  logic [N-1:0]    w_mag_a;
  logic [N-1:0]    w_mag_b;
  logic [N:0]      w_mul_sum;
  logic [2*N:0]    w_mul_next;
  logic [2*N-1:0]  w_prod;
  logic [N-1:0]    w_mul_res;
  logic [N-1:0]    w_fix_res;

`ifdef MULDIV_DIV_EN
  logic            r_neg_r;
  logic [2*N:0]    w_div_shift;
  logic [N:0]      w_div_diff;
  logic [2*N:0]    w_div_next;
  logic [N-1:0]    w_quo;
  logic [N-1:0]    w_rem;
  logic            w_div_zero;
  logic            w_ovf;
  logic [N-1:0]    w_fast_res;
`endif

  assign bus.busy_o = r_busy;
  assign bus.done_o = r_done;
  assign bus.res_o  = r_res;

  // Operand sign decode, iteration step and sign fixup datapath
  always_comb begin
    w_a_neg = bus.a_i[N-1] & ((bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                              (bus.op_i == 3'b100) || (bus.op_i == 3'b110));
    w_b_neg = bus.b_i[N-1] & ((bus.op_i == 3'b001) ||
                              (bus.op_i == 3'b100) || (bus.op_i == 3'b110));
    w_mag_a = w_a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
    w_mag_b = w_b_neg ? (~bus.b_i + 1'b1) : bus.b_i;

    // shift-add: add multiplicand to upper half when lsb set, then shift right
    w_mul_sum  = r_acc[2*N:N] + (r_acc[0] ? {1'b0, r_d} : {(N+1){1'b0}});
    w_mul_next = {1'b0, w_mul_sum, r_acc[N-1:1]};

    w_prod    = r_neg_q ? (~r_acc[2*N-1:0] + 1'b1) : r_acc[2*N-1:0];
    w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[N-1:0] : w_prod[2*N-1:N];

`ifdef MULDIV_DIV_EN
    // restoring divide: remainder in [2N:N], quotient shifts in at bit 0
    w_div_shift = {r_acc[2*N-1:0], 1'b0};
    w_div_diff  = w_div_shift[2*N:N] - {1'b0, r_d};
    w_div_next  = w_div_diff[N] ? w_div_shift
                                : {w_div_diff, w_div_shift[N-1:1], 1'b1};
    w_quo = r_neg_q ? (~r_acc[N-1:0] + 1'b1) : r_acc[N-1:0];
    w_rem = r_neg_r ? (~r_acc[2*N-1:N] + 1'b1) : r_acc[2*N-1:N];
    w_fix_res = r_op[2] ? (r_op[1] ? w_rem : w_quo) : w_mul_res;

    w_div_zero = (bus.b_i == '0);
    // op[0]=0 among divide ops selects the signed DIV/REM
    w_ovf      = (bus.a_i == {1'b1, {(N-1){1'b0}}}) && (bus.b_i == '1) && !bus.op_i[0];
    w_fast_res = bus.op_i[1] ? (w_div_zero ? bus.a_i : '0)
                             : (w_div_zero ? '1 : {1'b1, {(N-1){1'b0}}});
`else
    w_fix_res = r_op[2] ? '0 : w_mul_res;
`endif
  end

  // Control FSM and datapath registers; flush beats start, reset beats all
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_d     <= '0;
      r_acc   <= '0;
      r_neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_neg_r <= 1'b0;
`endif
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else if (bus.flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (bus.start_i) begin
            r_op    <= bus.op_i;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
            r_neg_r <= w_a_neg;
            if (bus.op_i[2] && (w_div_zero || w_ovf)) begin
              r_res   <= w_fast_res;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_d     <= bus.op_i[2] ? w_mag_b : w_mag_a;
              r_acc   <= {{(N+1){1'b0}}, (bus.op_i[2] ? w_mag_a : w_mag_b)};
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
`else
            if (bus.op_i[2]) begin
              r_res   <= '0;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_d     <= w_mag_a;
              r_acc   <= {{(N+1){1'b0}}, w_mag_b};
              r_state <= S_CALC;
              r_busy  <= 1'b1;
            end
`endif
          end
        end
        S_CALC: begin
`ifdef MULDIV_DIV_EN
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
`else
          r_acc <= w_mul_next;
`endif
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N-1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_res   <= w_fix_res;
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: multiply variants, divide (or its
// one-cycle stub when MULDIV_DIV_EN is undefined), flush, async reset,
// start held while busy and back-to-back issue.
module tb_muldiv_unit;
  localparam int N = 32;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  muldiv_unit_if #(.N(N)) bus ();

  muldiv_unit #(.N(N)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // drive start for exactly one edge, then scramble operands
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
    bus.op_i    = 3'($urandom);
  endtask

  // called in cycle 1 after the start edge; returns latency in cycles
  task automatic wait_done(output logic [31:0] res, output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!bus.done_o && lat < 200) begin
      if (bus.busy_o) busy_cnt++;
      @(posedge clk_i); #1;
      lat++;
    end
    res = bus.res_o;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat, bc;
    issue(op, a, b);
    wait_done(res, lat, bc);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [31:0] res;
    int lat, bc, dones;

    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.op_i    = '0;

    #1 rst_i = 1'b1;
    #20;
    chk("rst_busy", {31'b0, bus.busy_o}, 32'h0);
    chk("rst_done", {31'b0, bus.done_o}, 32'h0);
    chk("rst_res", bus.res_o, 32'h0);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;

    // MUL 7 * -7 with full latency and busy window
    issue(OP_MUL, 32'd7, 32'hFFFF_FFF9);
    wait_done(res, lat, bc);
    chk("mul_res", res, 32'hFFFF_FFCF);
    chk("mul_lat", 32'(lat), 32'd34);
    chk("mul_busy_cycles", 32'(bc), 32'd33);
    chk("mul_done_busy_low", {31'b0, bus.busy_o}, 32'h0);
    @(posedge clk_i); #1;
    chk("mul_done_pulse", {31'b0, bus.done_o}, 32'h0);

    run("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
    run("mul_neg_neg", OP_MUL, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15, 34);

`ifdef MULDIV_DIV_EN
    run("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem_neg",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("divu",      OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run("remu",      OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    run("divu_zero", OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_zero",  OP_REM,  32'h1234, 32'd0, 32'h1234, 1);
    run("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
`else
    run("div_stub",  OP_DIV,  32'd10, 32'd2, 32'd0, 1);
    run("remu_stub", OP_REMU, 32'd100, 32'd7, 32'd0, 1);
`endif

    // back-to-back: second start issued in the DONE cycle
    issue(OP_MUL, 32'd2, 32'd3);
    wait_done(res, lat, bc);
    chk("b2b_first_res", res, 32'd6);
    issue(OP_MUL, 32'd4, 32'd5);
    wait_done(res, lat, bc);
    chk("b2b_second_res", res, 32'd20);
    chk("b2b_second_lat", 32'(lat), 32'd34);

    // start held high while busy must give one result only
    bus.start_i = 1'b1;
    bus.op_i    = OP_MUL;
    bus.a_i     = 32'd6;
    bus.b_i     = 32'd7;
    @(posedge clk_i); #1;
    bus.a_i = $urandom;
    bus.b_i = $urandom;
    repeat (28) begin @(posedge clk_i); #1; end
    bus.start_i = 1'b0;
    dones = 0;
    res = '0;
    repeat (60) begin
      if (bus.done_o) begin dones++; res = bus.res_o; end
      @(posedge clk_i); #1;
    end
    chk("held_start_dones", 32'(dones), 32'd1);
    chk("held_start_res", res, 32'd42);

    // flush at cycle 10: idle at cycle 11, no done, result kept
    issue(OP_MUL, 32'd9, 32'd9);
    repeat (9) begin @(posedge clk_i); #1; end
    bus.flush_i = 1'b1;
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    chk("flush_busy", {31'b0, bus.busy_o}, 32'h0);
    dones = 0;
    repeat (40) begin
      if (bus.done_o) dones++;
      @(posedge clk_i); #1;
    end
    chk("flush_dones", 32'(dones), 32'd0);
    chk("flush_res_kept", bus.res_o, 32'd42);

    // async reset mid-CALC clears outputs before any edge
    issue(OP_MUL, 32'd11, 32'd13);
    repeat (5) begin @(posedge clk_i); #1; end
    chk("pre_rst_busy", {31'b0, bus.busy_o}, 32'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, bus.busy_o}, 32'h0);
    chk("midrst_done", {31'b0, bus.done_o}, 32'h0);
    chk("midrst_res", bus.res_o, 32'h0);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;
    run("after_rst_mul", OP_MUL, 32'd3, 32'd5, 32'd15, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
